// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter sharing the single write port of a packet FIFO among
//   NUM_REQ requesters. It registers the winning word onto the FIFO write
//   interface and runs the FIFO req/gnt handshake. Between words it always
//   returns to IDLE with fifo_write_req low for one cycle, which re-arms the
//   FIFO write enable. The FIFO write grant is relayed combinationally to the
//   owning requester.
//
//   Optional feature macro: FIFO_PKT_LOCK_EN
//     defined   : packet-atomic arbitration; the owner keeps the port until it
//                 has written a word with data[TAIL_BIT]=1.
//     undefined : per-word round-robin; TAIL_BIT is not used.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req_i           per-requester level request, held until gnt_o
//   data_i          requester k word at [k*DATA_W +: DATA_W]
//   gnt_o           one-cycle grant pulse to the owner (combinational)
//   fifo_write_req  FIFO write request (registered)
//   fifo_PacketIn   FIFO write data (registered)
//   fifo_write_gnt  FIFO write grant
//   fifo_full       FIFO full flag
//   owner_o         index of current/last winner (registered)
//   busy_o          high while waiting for the FIFO grant
module fifo_write_arbiter #(
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned DATA_W   = 36,
  parameter  int unsigned TAIL_BIT = 35,
  localparam int unsigned SEL_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      fifo_write_req,
  output logic [DATA_W-1:0]         fifo_PacketIn,
  input  logic                      fifo_write_gnt,
  input  logic                      fifo_full,
  output logic [SEL_W-1:0]          owner_o,
  output logic                      busy_o
);

  // Reject configurations the arbiter cannot support.
  if (NUM_REQ < 2 || TAIL_BIT >= DATA_W) begin : g_bad_cfg
    $error("fifo_write_arbiter: NUM_REQ must be >= 2 and TAIL_BIT < DATA_W");
  end

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_GNT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                write_req_q, write_req_d;
  logic [DATA_W-1:0]   packet_q, packet_d;
  logic [SEL_W-1:0]    owner_q, owner_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
`ifdef FIFO_PKT_LOCK_EN
  logic                lock_q, lock_d;
`endif

  logic [NUM_REQ-1:0]  eligible;
  logic                found;
  logic [SEL_W-1:0]    winner;
  logic [SEL_W-1:0]    cand;
  logic [SEL_W-1:0]    owner_next;

  // Requests that may compete this cycle; a locked packet owner excludes others.
  always_comb begin
    eligible = req_i;
`ifdef FIFO_PKT_LOCK_EN
    if (lock_q) begin
      eligible = req_i & (NUM_REQ'(1) << owner_q);
    end
`endif
  end

  // First eligible requester scanning from rr_ptr upward, modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = SEL_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Round-robin successor of the current owner, wrapping NUM_REQ-1 to 0.
  always_comb begin
    if (owner_q == SEL_W'(NUM_REQ - 1)) begin
      owner_next = '0;
    end else begin
      owner_next = owner_q + SEL_W'(1);
    end
  end

  // Next-state and grant logic.
  always_comb begin
    state_d     = state_q;
    write_req_d = write_req_q;
    packet_d    = packet_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef FIFO_PKT_LOCK_EN
    lock_d      = lock_q;
`endif
    gnt_o       = '0;

    case (state_q)
      ST_IDLE: begin
        write_req_d = 1'b0;
        if (!fifo_full && found) begin
          owner_d     = winner;
          packet_d    = data_i[32'(winner) * DATA_W +: DATA_W];
          write_req_d = 1'b1;
          state_d     = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        // req_i is not sampled here, so a requester updating its word at the
        // grant edge cannot cause a second write of the same word.
        if (fifo_write_gnt) begin
          gnt_o[owner_q] = 1'b1;
          write_req_d    = 1'b0;
          state_d        = ST_IDLE;
`ifdef FIFO_PKT_LOCK_EN
          if (packet_q[TAIL_BIT]) begin
            lock_d   = 1'b0;
            rr_ptr_d = owner_next;
          end else begin
            lock_d   = 1'b1;
          end
`else
          rr_ptr_d = owner_next;
`endif
        end
      end
      default: begin
        state_d     = ST_IDLE;
        write_req_d = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      write_req_q <= 1'b0;
      packet_q    <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
`ifdef FIFO_PKT_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      write_req_q <= write_req_d;
      packet_q    <= packet_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef FIFO_PKT_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign fifo_write_req = write_req_q;
  assign fifo_PacketIn  = packet_q;
  assign owner_o        = owner_q;
  assign busy_o         = (state_q == ST_WAIT_GNT);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a small FIFO write-port model
// and per-requester word queues that advance on gnt_o.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 36;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_i;
  logic [NR*DW-1:0]  data_i;
  logic [NR-1:0]     gnt_o;
  logic              fifo_write_req;
  logic [DW-1:0]     fifo_PacketIn;
  logic              fifo_write_gnt;
  logic              fifo_full;
  logic [1:0]        owner_o;
  logic              busy_o;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TAIL_BIT(35)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .data_i         (data_i),
    .gnt_o          (gnt_o),
    .fifo_write_req (fifo_write_req),
    .fifo_PacketIn  (fifo_PacketIn),
    .fifo_write_gnt (fifo_write_gnt),
    .fifo_full      (fifo_full),
    .owner_o        (owner_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO write-port model: writes when write_req is seen armed and not full,
  // grants for one cycle, and re-arms only after write_req has been low.
  logic        model_gnt;
  logic        armed;
  logic        hold;
  logic        force_gnt;
  int unsigned cyc = 0;
  logic [DW-1:0] wlog[$];
  int unsigned   wtime[$];
  int            glog[$];

  assign fifo_write_gnt = model_gnt | force_gnt;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      model_gnt <= 1'b0;
      armed     <= 1'b1;
    end else begin
      if (fifo_write_req && armed && !fifo_full && !hold) begin
        model_gnt <= 1'b1;
        armed     <= 1'b0;
        wlog.push_back(fifo_PacketIn);
        wtime.push_back(cyc);
      end else begin
        model_gnt <= 1'b0;
      end
      if (!fifo_write_req) armed <= 1'b1;
    end
  end

  // Requester word storage.
  logic [DW-1:0] words [NR][8];
  int            head  [NR];
  int            cnt   [NR];

  task automatic drive_reqs();
    for (int k = 0; k < NR; k++) begin
      if (head[k] < cnt[k]) begin
        req_i[k] = 1'b1;
        data_i[k*DW +: DW] = words[k][head[k]];
      end else begin
        req_i[k] = 1'b0;
        data_i[k*DW +: DW] = '0;
      end
    end
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < NR; k++) begin
      head[k] = 0;
      cnt[k]  = 0;
    end
    drive_reqs();
  endtask

  task automatic load(input int k, input logic [DW-1:0] w);
    words[k][cnt[k]] = w;
    cnt[k] = cnt[k] + 1;
  endtask

  // One cycle: sample at negedge, log/pop grants, re-drive requesters.
  task automatic step();
    @(negedge clk);
    if (gnt_o !== '0) begin
      checks++;
      if ($countones(gnt_o) != 1 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL gnt_onehot: gnt_o=%b busy_o=%b required one-hot while busy", gnt_o, busy_o);
      end
      for (int k = 0; k < NR; k++) begin
        if (gnt_o[k]) begin
          glog.push_back(k);
          head[k] = head[k] + 1;
        end
      end
    end
    drive_reqs();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int c = 0;
    while (glog.size() < n && c < budget) begin
      step();
      c++;
    end
    checks++;
    if (glog.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: grants=%0d required=%0d", name, glog.size(), n);
    end
  endtask

  task automatic test_reset();
    clear_reqs();
    fifo_full = 1'b0;
    hold      = 1'b0;
    force_gnt = 1'b0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (fifo_write_req !== 1'b0 || fifo_PacketIn !== '0 || owner_o !== 2'd0 ||
        busy_o !== 1'b0 || gnt_o !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%b pkt=%h owner=%0d busy=%b gnt=%b required all zero",
               fifo_write_req, fifo_PacketIn, owner_o, busy_o, gnt_o);
    end
    rst = 1'b0;
    glog.delete();
    wlog.delete();
    wtime.delete();
  endtask

  task automatic test_single();
    test_reset();
    load(1, 36'h0_0000_00AB);
    step();
    step();
    checks++;
    if (fifo_write_req !== 1'b1 || fifo_PacketIn !== 36'h0_0000_00AB || owner_o !== 2'd1 ||
        busy_o !== 1'b1 || gnt_o !== 4'b0000) begin
      errors++;
      $display("FAIL single_issue: req=%b pkt=%h owner=%0d busy=%b gnt=%b required 1/AB/1/1/0000",
               fifo_write_req, fifo_PacketIn, owner_o, busy_o, gnt_o);
    end
    step();
    checks++;
    if (gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL single_gnt: gnt_o=%b required 0010", gnt_o);
    end
    checks++;
    if (wlog.size() != 1 || wlog[0] !== 36'h0_0000_00AB) begin
      errors++;
      $display("FAIL single_write: writes=%0d first=%h required 1 x AB", wlog.size(), wlog[0]);
    end
    step();
    checks++;
    if (fifo_write_req !== 1'b0 || busy_o !== 1'b0 || gnt_o !== '0) begin
      errors++;
      $display("FAIL single_rearm: req=%b busy=%b gnt=%b required 0/0/0000",
               fifo_write_req, busy_o, gnt_o);
    end
  endtask

  task automatic test_back_to_back();
    int exp_g [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    test_reset();
    for (int k = 0; k < NR; k++) begin
      load(k, DW'(36'h0_0000_0010 + k));
      load(k, DW'(36'h0_0000_0100 + k));
    end
    run_until(8, 60, "rr");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (glog.size() <= i || glog[i] != exp_g[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got=%0d required=%0d", i, (glog.size() > i) ? glog[i] : -1, exp_g[i]);
      end
    end
    checks++;
    if (wlog.size() < 5 || wlog[4] !== 36'h0_0000_0100) begin
      errors++;
      $display("FAIL rr_data: word4=%h required 000000100", wlog[4]);
    end
    for (int i = 0; i + 1 < 8; i++) begin
      checks++;
      if (wtime.size() < 8 || wtime[i+1] - wtime[i] != 3) begin
        errors++;
        $display("FAIL rr_spacing[%0d]: gap=%0d required=3", i,
                 (wtime.size() >= 8) ? int'(wtime[i+1] - wtime[i]) : -1);
      end
    end
  endtask

  task automatic test_full();
    test_reset();
    fifo_full = 1'b1;
    load(0, 36'h0_0000_0005);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (fifo_write_req !== 1'b0 || gnt_o !== '0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL full_stall[%0d]: req=%b gnt=%b busy=%b required 0/0000/0",
                 i, fifo_write_req, gnt_o, busy_o);
      end
    end
    fifo_full = 1'b0;
    step();
    checks++;
    if (fifo_write_req !== 1'b1 || fifo_PacketIn !== 36'h0_0000_0005) begin
      errors++;
      $display("FAIL full_release: req=%b pkt=%h required 1/5", fifo_write_req, fifo_PacketIn);
    end
    run_until(1, 10, "full");
    checks++;
    if (glog.size() < 1 || glog[0] != 0) begin
      errors++;
      $display("FAIL full_owner: got=%0d required=0", (glog.size() > 0) ? glog[0] : -1);
    end
  endtask

  task automatic test_spurious();
    test_reset();
    force_gnt = 1'b1;
    step();
    step();
    checks++;
    if (gnt_o !== '0 || busy_o !== 1'b0 || fifo_write_req !== 1'b0) begin
      errors++;
      $display("FAIL spurious_gnt: gnt=%b busy=%b req=%b required 0000/0/0", gnt_o, busy_o, fifo_write_req);
    end
    force_gnt = 1'b0;
  endtask

  task automatic test_reset_mid();
    test_reset();
    load(1, 36'h0_0000_0011);
    run_until(1, 10, "rmid_pre");
    step();
    hold = 1'b1;
    load(3, 36'h0_0000_0033);
    step();
    step();
    checks++;
    if (busy_o !== 1'b1 || owner_o !== 2'd3) begin
      errors++;
      $display("FAIL rmid_wait: busy=%b owner=%0d required 1/3", busy_o, owner_o);
    end
    load(0, 36'h0_0000_000A);
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (fifo_write_req !== 1'b0 || gnt_o !== '0 || busy_o !== 1'b0 || owner_o !== 2'd0) begin
      errors++;
      $display("FAIL rmid_reset: req=%b gnt=%b busy=%b owner=%0d required 0/0000/0/0",
               fifo_write_req, gnt_o, busy_o, owner_o);
    end
    rst  = 1'b0;
    hold = 1'b0;
    glog.delete();
    wlog.delete();
    run_until(2, 20, "rmid_post");
    checks++;
    if (glog.size() < 2 || glog[0] != 0 || glog[1] != 3) begin
      errors++;
      $display("FAIL rmid_order: first=%0d second=%0d required 0 then 3",
               (glog.size() > 0) ? glog[0] : -1, (glog.size() > 1) ? glog[1] : -1);
    end
  endtask

  task automatic test_drop();
    test_reset();
    hold = 1'b1;
    load(2, 36'h0_0000_00D2);
    step();
    step();
    cnt[2] = 0;
    step();
    checks++;
    if (req_i[2] !== 1'b0 || busy_o !== 1'b1 || owner_o !== 2'd2) begin
      errors++;
      $display("FAIL drop_wait: req2=%b busy=%b owner=%0d required 0/1/2", req_i[2], busy_o, owner_o);
    end
    hold = 1'b0;
    run_until(1, 10, "drop");
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (wlog.size() != 1 || wlog[0] !== 36'h0_0000_00D2 || glog.size() != 1 || glog[0] != 2) begin
      errors++;
      $display("FAIL drop_complete: writes=%0d word=%h grants=%0d required 1 x D2 to 2",
               wlog.size(), wlog[0], glog.size());
    end
  endtask

  task automatic test_pkt_lock();
    int exp_g [5];
`ifdef FIFO_PKT_LOCK_EN
    exp_g = '{0, 0, 0, 1, 1};
`else
    exp_g = '{0, 1, 0, 1, 0};
`endif
    test_reset();
    load(0, 36'h0_0000_0001);
    load(0, 36'h0_0000_0002);
    load(0, 36'h8_0000_0003);
    load(1, 36'h8_0000_0011);
    load(1, 36'h8_0000_0012);
    run_until(5, 40, "pkt");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (glog.size() <= i || glog[i] != exp_g[i]) begin
        errors++;
        $display("FAIL pkt_order[%0d]: got=%0d required=%0d", i, (glog.size() > i) ? glog[i] : -1, exp_g[i]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_i     = '0;
    data_i    = '0;
    fifo_full = 1'b0;
    hold      = 1'b0;
    force_gnt = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_spurious();
    test_reset_mid();
    test_drop();
    test_pkt_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
